// File: rtl/mrf_pkg.sv
// Shared types and parameter helpers for the matrix row fetcher.
package mrf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_UNPACK    = 3'd3,
    ST_DONE      = 3'd4
  } mrf_state_t;

  // Elements carried by one bus word.
  function automatic int unsigned mrf_epw(input int unsigned bus_w, input int unsigned data_w);
    return (data_w == 0) ? 0 : bus_w / data_w;
  endfunction

  // Bus words making up one row.
  function automatic int unsigned mrf_wpr(input int unsigned row_len, input int unsigned bus_w,
                                          input int unsigned data_w);
    int unsigned epw;
    epw = mrf_epw(bus_w, data_w);
    return (epw == 0) ? 0 : row_len / epw;
  endfunction

  // Counter width able to index n items, never below one bit.
  function automatic int unsigned mrf_cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mrf_word_unpacker.sv
// Holds one captured bus word and steps through its elements, one per write.
// MRF_LSB_FIRST_EN selects ascending element order; default is MSB-first.
module mrf_word_unpacker
  import mrf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BUS_WIDTH-1:0]  load_word,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] elem_c,
  output logic                  last_elem_c
);

  localparam int unsigned EPW = mrf_epw(BUS_WIDTH, DATA_WIDTH);
  localparam int unsigned EW  = mrf_cnt_w(EPW);

  logic [BUS_WIDTH-1:0] word_q, word_d;
  logic [EW-1:0]        elem_q, elem_d;
  logic [BUS_WIDTH-1:0] shifted_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      elem_q <= '0;
    end else begin
      word_q <= word_d;
      elem_q <= elem_d;
    end
  end

  assign last_elem_c = (elem_q == EW'(EPW - 1));

  always_comb begin
    word_d = word_q;
    elem_d = elem_q;
    if (load) begin
      word_d = load_word;
      elem_d = '0;
    end else if (advance) begin
      elem_d = last_elem_c ? '0 : elem_q + EW'(1);
    end
  end

  // Shift the selected element to the read-out end of the word.
`ifdef MRF_LSB_FIRST_EN
  always_comb begin
    shifted_c = word_q >> (32'(elem_q) * DATA_WIDTH);
    elem_c    = shifted_c[DATA_WIDTH-1:0];
  end
`else
  always_comb begin
    shifted_c = word_q << (32'(elem_q) * DATA_WIDTH);
    elem_c    = shifted_c[BUS_WIDTH-1 -: DATA_WIDTH];
  end
`endif

endmodule

// File: rtl/matrix_row_fetcher.sv
// Avalon-MM read master that streams NUM_ROWS rows into per-row FIFOs.
// Optional MRF_LSB_FIRST_EN (in the unpacker) reverses element order within a word.
module matrix_row_fetcher
  import mrf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned NUM_ROWS   = 8,
  parameter int unsigned ROW_LEN    = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH-1:0]          row_stride,
  output logic                           busy,
  output logic                           fetch_done,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic                           mem_read,
  input  logic [BUS_WIDTH-1:0]           mem_readdata,
  input  logic                           mem_readdatavalid,
  input  logic                           mem_waitrequest,
  output logic [NUM_ROWS-1:0]            fifo_wren,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] fifo_data,
  input  logic [NUM_ROWS-1:0]            fifo_full
);

  localparam int unsigned EPW    = mrf_epw(BUS_WIDTH, DATA_WIDTH);
  localparam int unsigned WPR    = mrf_wpr(ROW_LEN, BUS_WIDTH, DATA_WIDTH);
  localparam int unsigned ROW_W  = mrf_cnt_w(NUM_ROWS);
  localparam int unsigned WORD_W = mrf_cnt_w(WPR);

  if (DATA_WIDTH == 0 || (BUS_WIDTH % DATA_WIDTH) != 0) begin : g_bad_bus
    $error("BUS_WIDTH must be a non-zero multiple of DATA_WIDTH");
  end
  if (EPW == 0 || (ROW_LEN % EPW) != 0 || WPR == 0) begin : g_bad_row
    $error("ROW_LEN must be a non-zero multiple of BUS_WIDTH/DATA_WIDTH");
  end
  if (NUM_ROWS < 1) begin : g_bad_rows
    $error("NUM_ROWS must be at least 1");
  end

  mrf_state_t            state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  wr_c;
  logic                  load_c;
  logic                  last_elem_c;
  logic                  last_word_c;
  logic                  last_row_c;
  logic [DATA_WIDTH-1:0] elem_c;

  assign last_word_c = (word_q == WORD_W'(WPR - 1));
  assign last_row_c  = (row_q == ROW_W'(NUM_ROWS - 1));
  assign load_c      = (state_q == ST_WAIT_DATA) && mem_readdatavalid;

  mrf_word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_unpacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_c),
    .load_word   (mem_readdata),
    .advance     (wr_c),
    .elem_c      (elem_c),
    .last_elem_c (last_elem_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      word_q     <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      word_q     <= word_d;
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_REQ;
      ST_REQ:       if (!mem_waitrequest) state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: if (mem_readdatavalid) state_d = ST_UNPACK;
      ST_UNPACK:    if (wr_c && last_elem_c) state_d = (last_word_c && last_row_c) ? ST_DONE : ST_REQ;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Row/word walk; the address tracks row_base + word incrementally.
  always_comb begin
    row_d      = row_q;
    word_d     = word_q;
    stride_d   = stride_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (state_q == ST_IDLE && start) begin
      row_d      = '0;
      word_d     = '0;
      stride_d   = row_stride;
      row_base_d = base_addr;
      addr_d     = base_addr;
    end else if (state_q == ST_UNPACK && wr_c && last_elem_c) begin
      if (!last_word_c) begin
        word_d = word_q + WORD_W'(1);
        addr_d = addr_q + ADDR_WIDTH'(1);
      end else begin
        word_d = '0;
        if (!last_row_c) begin
          row_d      = row_q + ROW_W'(1);
          row_base_d = row_base_q + stride_q;
          addr_d     = row_base_q + stride_q;
        end
      end
    end
  end

  // FIFO enables follow fifo_full combinationally so a full FIFO is never written.
  always_comb begin
    mem_read    = (state_q == ST_REQ);
    mem_address = addr_q;
    busy        = (state_q != ST_IDLE);
    fetch_done  = (state_q == ST_DONE);
    fifo_data   = {NUM_ROWS{elem_c}};
    fifo_wren   = '0;
    if (state_q == ST_UNPACK) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (row_q == ROW_W'(r)) fifo_wren[r] = !fifo_full[r];
      end
    end
    wr_c = |fifo_wren;
  end

endmodule

// File: tb/tb_matrix_row_fetcher.sv
// Scoreboard bench for matrix_row_fetcher: memory model pushes expected elements, FIFO monitor pops.
module tb_matrix_row_fetcher;

  localparam int DW  = 8;
  localparam int BW  = 64;
  localparam int NR  = 8;
  localparam int RL  = 16;
  localparam int AW  = 32;
  localparam int EPW = BW / DW;
  localparam int WPR = RL / EPW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW-1:0]     row_stride = '0;
  logic              busy, fetch_done, mem_read;
  logic [AW-1:0]     mem_address;
  logic [BW-1:0]     mem_readdata = '0;
  logic              mem_readdatavalid = 1'b0;
  logic              mem_waitrequest = 1'b0;
  logic [NR-1:0]     fifo_wren;
  logic [NR*DW-1:0]  fifo_data;
  logic [NR-1:0]     fifo_full = '0;

  matrix_row_fetcher #(
    .DATA_WIDTH (DW), .BUS_WIDTH (BW), .NUM_ROWS (NR), .ROW_LEN (RL), .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .base_addr (base_addr), .row_stride (row_stride),
    .busy (busy), .fetch_done (fetch_done), .mem_address (mem_address), .mem_read (mem_read),
    .mem_readdata (mem_readdata), .mem_readdatavalid (mem_readdatavalid),
    .mem_waitrequest (mem_waitrequest), .fifo_wren (fifo_wren), .fifo_data (fifo_data),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] m_base, m_stride;
  int            req_idx = 0;
  int            tot_wr = 0;
  int            done_cnt = 0;
  int            row_wr[NR];
  int            stall_at = -1;
  int            stall_left = 0;
  bit            pend = 1'b0;
  logic [AW-1:0] pend_addr;
  int            pend_row;
  bit            ignore_rdv = 1'b0;
  bit            full_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
    return 64'h0102030405060708 + BW'(a);
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int idx);
    return m_base + AW'(idx / WPR) * m_stride + AW'(idx % WPR);
  endfunction

  // Memory model: one-cycle read latency, optional waitrequest stall on a chosen request.
  always @(negedge clk) begin
    logic [BW-1:0] w;
    exp_t          e;
    mem_readdatavalid = 1'b0;
    if (pend) begin
      pend = 1'b0;
      w = mem_word(pend_addr);
      mem_readdata = w;
      mem_readdatavalid = 1'b1;
      if (!ignore_rdv) begin
        for (int k = 0; k < EPW; k++) begin
          e.row = pend_row;
`ifdef MRF_LSB_FIRST_EN
          e.data = w[DW*k +: DW];
`else
          e.data = w[(BW-1-DW*k) -: DW];
`endif
          exp_q.push_back(e);
        end
      end
    end
    mem_waitrequest = 1'b0;
    if (mem_read) begin
      if (req_idx == stall_at && stall_left > 0) begin
        mem_waitrequest = 1'b1;
        stall_left--;
        check("stall_addr", mem_address, exp_addr(req_idx));
      end else begin
        check("addr", mem_address, exp_addr(req_idx));
        pend = 1'b1;
        pend_addr = mem_address;
        pend_row = req_idx / WPR;
        req_idx++;
      end
    end
  end

  // FIFO-side monitor.
  always @(negedge clk) begin
    exp_t e;
    if (fifo_wren != '0) begin
      tot_wr++;
      check("wr_into_full", 64'(fifo_wren & fifo_full), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 64'(fifo_wren), 64'd0);
      end else begin
        e = exp_q.pop_front();
        row_wr[e.row]++;
        check("wren", 64'(fifo_wren), 64'd1 << e.row);
        check("data", 64'(fifo_data), 64'({NR{e.data}}));
      end
    end
    if (fetch_done) begin
      done_cnt++;
      check("done_writes", 64'(tot_wr), 64'(NR * RL));
      check("done_queue", 64'(exp_q.size()), 64'd0);
      check("done_reads", 64'(req_idx), 64'(NR * WPR));
    end
  end

  // Caller is at posedge+1; start is sampled at the next edge.
  task automatic run_fetch(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input string tag, input int mode);
    int  cyc;
    int  fcyc;
    bit  full_on;
    m_base = base;
    m_stride = stride;
    req_idx = 0;
    tot_wr = 0;
    done_cnt = 0;
    for (int r = 0; r < NR; r++) row_wr[r] = 0;
    base_addr = base;
    row_stride = stride;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ~base;
    row_stride = ~stride;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cyc = 0;
    fcyc = 0;
    full_on = 1'b0;
    while (done_cnt == 0 && cyc < 5000) begin
      if (mode == 1) begin
        if (cyc == 5) begin
          start = 1'b1;
          base_addr = 32'h999;
          row_stride = 32'h7;
        end else if (cyc == 6) begin
          start = 1'b0;
        end
        if (full_on) begin
          check("stall_wren2", 64'(fifo_wren[2]), 64'd0);
          check("stall_read", 64'(mem_read), 64'd0);
          fcyc++;
          if (fcyc == 10) begin
            fifo_full = '0;
            full_on = 1'b0;
            full_done = 1'b1;
          end
        end else if (!full_done && row_wr[2] >= 3) begin
          fifo_full = NR'(1) << 2;
          full_on = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_pulse"}, 64'(fetch_done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(fetch_done), 64'd0);
    check({tag, "_read"}, 64'(mem_read), 64'd0);
    check({tag, "_addr"}, 64'(mem_address), 64'd0);
    check({tag, "_wren"}, 64'(fifo_wren), 64'd0);
    check({tag, "_data"}, 64'(fifo_data), 64'd0);
  endtask

  // Reset while a read is outstanding; its late readdatavalid must be ignored.
  task automatic reset_midflight();
    int cyc;
    m_base = 32'h40;
    m_stride = 32'h2;
    req_idx = 0;
    tot_wr = 0;
    done_cnt = 0;
    base_addr = m_base;
    row_stride = m_stride;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (req_idx < 3 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reached_wait", 64'(req_idx), 64'd3);
    ignore_rdv = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_late_rdv_wren", 64'(fifo_wren), 64'd0);
    check("rst_late_rdv_busy", 64'(busy), 64'd0);
    check("rst_late_rdv_read", 64'(mem_read), 64'd0);
    @(posedge clk); #1;
    check("rst_after_wren", 64'(fifo_wren), 64'd0);
    exp_q.delete();
    ignore_rdv = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    stall_at = 2;
    stall_left = 5;
    run_fetch(32'h0, 32'h2, "t1", 0);
    check("t1_wait_used", 64'(stall_left), 64'd0);
    stall_at = -1;

    run_fetch(32'h100, 32'h4, "t2", 0);
    run_fetch(32'h20, 32'h2, "t3", 1);
    check("t3_full_stall_seen", 64'(full_done), 64'd1);
    run_fetch(32'hFFFF_FFFC, 32'h3, "t4", 0);

    reset_midflight();
    run_fetch(32'h0, 32'h1, "t6", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
